instr_decode: RTL

- Sits directly downstream of the program-counter/fetch stage.
- Consumes the 8-bit instruction bytes it delivers and assembles one- and two-byte instructions.
- Issues decoded micro-ops to the register/ALU stage.
- Drives jmp/addr back to the fetch stage for taken branches.
- Owns halt state and the one-byte flush after a taken jump.

---
 rtl/instr_decode_pkg.sv | 38 +++
 rtl/instr_decode_fields.sv | 25 ++
 rtl/instr_decode.sv | 114 +++++++++++
 3 files changed

// File: rtl/instr_decode_pkg.sv
// Shared ISA definitions for the byte-serial decoder: opcodes, field positions,
// instruction-length rule and the decoder FSM encoding.
package chocolate_isa_pkg;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_LDI = 4'h1;
  localparam logic [3:0] OP_MOV = 4'h2;
  localparam logic [3:0] OP_ADD = 4'h3;
  localparam logic [3:0] OP_SUB = 4'h4;
  localparam logic [3:0] OP_JMP = 4'h8;
  localparam logic [3:0] OP_JZ  = 4'h9;
  localparam logic [3:0] OP_HLT = 4'hF;

  localparam int OPC_MSB = 7;
  localparam int OPC_LSB = 4;
  localparam int RD_MSB  = 3;
  localparam int RD_LSB  = 2;
  localparam int RS_MSB  = 1;
  localparam int RS_LSB  = 0;

  typedef enum logic [2:0] {
    ST_OP    = 3'd0,
    ST_IMM   = 3'd1,
    ST_ISSUE = 3'd2,
    ST_FLUSH = 3'd3,
    ST_HALT  = 3'd4
  } state_t;

  function automatic logic is_two_byte(input logic [3:0] opcode);
    return (opcode == OP_LDI) || (opcode == OP_JMP) || (opcode == OP_JZ);
  endfunction

  function automatic logic is_defined(input logic [3:0] opcode);
    return is_two_byte(opcode) || (opcode == OP_NOP) || (opcode == OP_MOV) ||
           (opcode == OP_ADD) || (opcode == OP_SUB) || (opcode == OP_HLT);
  endfunction

endpackage

// File: rtl/instr_decode_fields.sv
// Combinational split of an instruction's first byte into opcode, register
// fields and the two-byte flag; undefined opcodes are folded to NOP here.
module instr_fields
  import chocolate_isa_pkg::*;
#(
  parameter int RW = 2
) (
  input  logic [7:0]    instr_byte,
  output logic [3:0]    op,
  output logic [RW-1:0] rd,
  output logic [RW-1:0] rs,
  output logic          two_byte
);

  logic [3:0] raw_op;

  always_comb begin
    raw_op   = instr_byte[OPC_MSB:OPC_LSB];
    op       = is_defined(raw_op) ? raw_op : OP_NOP;
    rd       = instr_byte[RD_LSB +: RW];
    rs       = instr_byte[RS_LSB +: RW];
    two_byte = is_two_byte(raw_op);
  end

endmodule

// File: rtl/instr_decode.sv
// Byte-serial instruction decoder: assembles 1/2-byte instructions from fetch,
// issues micro-ops, redirects fetch on taken jumps and owns halt/flush state.
module instr_decode
  import chocolate_isa_pkg::*;
#(
  parameter int NREG            = 4,
  parameter int FLUSH_AFTER_JMP = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     instr_valid,
  input  logic [7:0]               instr,
  output logic                     instr_ready,
  input  logic                     zero_flag,
  output logic                     uop_valid,
  input  logic                     uop_ready,
  output logic [3:0]               uop_op,
  output logic [$clog2(NREG)-1:0]  uop_rd,
  output logic [$clog2(NREG)-1:0]  uop_rs,
  output logic [7:0]               uop_imm,
  output logic                     load_imm,
  output logic                     jmp,
  output logic [7:0]               addr,
  output logic                     halted,
  output state_t                   dbg_state
);

  localparam int RW = $clog2(NREG);
  localparam int FW = (FLUSH_AFTER_JMP > 1) ? $clog2(FLUSH_AFTER_JMP) : 1;
  localparam logic [FW-1:0] FLUSH_LAST = FW'((FLUSH_AFTER_JMP > 0) ? FLUSH_AFTER_JMP - 1 : 0);

  state_t         state, state_nxt;
  logic [3:0]     op_q;
  logic [RW-1:0]  rd_q, rs_q;
  logic [7:0]     imm_q;
  logic [FW-1:0]  flush_cnt;

  logic [3:0]     f_op;
  logic [RW-1:0]  f_rd, f_rs;
  logic           f_two;
  logic           xfer, retire, taken;

  instr_fields #(.RW(RW)) u_fields (
    .instr_byte (instr),
    .op         (f_op),
    .rd         (f_rd),
    .rs         (f_rs),
    .two_byte   (f_two)
  );

  // Both interfaces are valid/ready: a transfer happens at the posedge where
  // valid && ready; the producer holds data stable until then, ready never
  // depends on valid, and valid never waits on ready.
  assign xfer   = instr_valid && instr_ready;
  assign retire = (state == ST_ISSUE) && uop_ready;
  assign taken  = (op_q == OP_JMP) || ((op_q == OP_JZ) && zero_flag);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_OP;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_OP:    if (xfer) state_nxt = f_two ? ST_IMM : ST_ISSUE;
      ST_IMM:   if (xfer) state_nxt = ST_ISSUE;
      ST_ISSUE: if (retire) begin
        if (op_q == OP_HLT)                     state_nxt = ST_HALT;
        else if (taken && (FLUSH_AFTER_JMP > 0)) state_nxt = ST_FLUSH;
        else                                    state_nxt = ST_OP;
      end
      ST_FLUSH: if (xfer && (flush_cnt == FLUSH_LAST)) state_nxt = ST_OP;
      ST_HALT:  state_nxt = ST_HALT;
      default:  state_nxt = ST_OP;
    endcase
  end

  always_comb begin
    instr_ready = (state == ST_OP) || (state == ST_IMM) || (state == ST_FLUSH);
    uop_valid   = (state == ST_ISSUE);
    uop_op      = uop_valid ? op_q  : OP_NOP;
    uop_rd      = uop_valid ? rd_q  : '0;
    uop_rs      = uop_valid ? rs_q  : '0;
    uop_imm     = uop_valid ? imm_q : '0;
    load_imm    = uop_valid && (op_q == OP_LDI);
    jmp         = retire && taken;
    addr        = jmp ? imm_q : '0;
    halted      = (state == ST_HALT);
    dbg_state   = state;
  end

  // imm is cleared on the first byte so one-byte instructions issue imm=0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q      <= OP_NOP;
      rd_q      <= '0;
      rs_q      <= '0;
      imm_q     <= '0;
      flush_cnt <= '0;
    end else begin
      if ((state == ST_OP) && xfer) begin
        op_q  <= f_op;
        rd_q  <= f_rd;
        rs_q  <= f_rs;
        imm_q <= '0;
      end
      if ((state == ST_IMM) && xfer) imm_q <= instr;
      if (retire)                             flush_cnt <= '0;
      else if ((state == ST_FLUSH) && xfer)   flush_cnt <= flush_cnt + 1'b1;
    end
  end

endmodule
